// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: load-use stalls, redirect flushes,
// data-memory freezes with a watchdog, and saturating stall/flush counters.
module hazard_ctrl #(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       IFID_rs1_i,
    input  logic [4:0]       IFID_rs2_i,
    input  logic             IFID_rs1_used_i,
    input  logic             IFID_rs2_used_i,
    input  logic [4:0]       IDEX_rd_i,
    input  logic             IDEX_rd_wren_i,
    input  logic             IDEX_memrd_i,
    input  logic             EX_redirect_i,
    input  logic             dmem_req_i,
    input  logic             dmem_ack_i,
    output logic             pc_en_o,
    output logic             IFID_en_o,
    output logic             IFID_flush_o,
    output logic             IDEX_en_o,
    output logic             IDEX_flush_o,
    output logic             EXMEM_en_o,
    output logic             MEMWB_bubble_o,
    output logic             mem_timeout_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam int unsigned         WCNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [WCNT_W-1:0]   WCNT_MAX = WCNT_W'(TIMEOUT);
    localparam logic [WCNT_W-1:0]   WCNT_ONE = WCNT_W'(1);

    typedef enum logic [1:0] {
        S_RUN,
        S_MEM_WAIT,
        S_TIMEOUT
    } state_t;

    state_t            state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              timeout_d;
    logic              frozen;
    logic              load_use;
    logic              rs1_hit;
    logic              rs2_hit;
    logic              redirect_taken;
    logic              stall_evt;

    assign rs1_hit  = IFID_rs1_used_i && (IFID_rs1_i == IDEX_rd_i);
    assign rs2_hit  = IFID_rs2_used_i && (IFID_rs2_i == IDEX_rd_i);
    assign load_use = IDEX_memrd_i && IDEX_rd_wren_i && (IDEX_rd_i != 5'd0)
                      && (rs1_hit || rs2_hit);

    always_comb begin
        frozen = 1'b0;
        unique case (state_q)
            S_RUN:      frozen = dmem_req_i && !dmem_ack_i;
            S_MEM_WAIT: frozen = !dmem_ack_i;
            S_TIMEOUT:  frozen = 1'b1;
            default:    frozen = 1'b1;
        endcase
    end

    // Output priority: reset, freeze, redirect, load-use, normal flow.
    always_comb begin
        pc_en_o        = 1'b1;
        IFID_en_o      = 1'b1;
        IFID_flush_o   = 1'b0;
        IDEX_en_o      = 1'b1;
        IDEX_flush_o   = 1'b0;
        EXMEM_en_o     = 1'b1;
        MEMWB_bubble_o = 1'b0;
        if (rst_i) begin
            pc_en_o        = 1'b0;
            IFID_en_o      = 1'b0;
            IFID_flush_o   = 1'b1;
            IDEX_en_o      = 1'b0;
            IDEX_flush_o   = 1'b1;
            EXMEM_en_o     = 1'b0;
            MEMWB_bubble_o = 1'b1;
        end else if (frozen) begin
            pc_en_o        = 1'b0;
            IFID_en_o      = 1'b0;
            IDEX_en_o      = 1'b0;
            EXMEM_en_o     = 1'b0;
            MEMWB_bubble_o = 1'b1;
        end else if (EX_redirect_i) begin
            IFID_flush_o = 1'b1;
            IDEX_flush_o = 1'b1;
        end else if (load_use) begin
            pc_en_o      = 1'b0;
            IFID_en_o    = 1'b0;
            IDEX_flush_o = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        timeout_d = mem_timeout_o;
        unique case (state_q)
            S_RUN: begin
                if (frozen) begin
                    state_d = S_MEM_WAIT;
                    wcnt_d  = WCNT_ONE;
                end
            end
            S_MEM_WAIT: begin
                if (dmem_ack_i) begin
                    state_d = S_RUN;
                    wcnt_d  = '0;
                end else if (wcnt_q == WCNT_MAX) begin
                    state_d   = S_TIMEOUT;
                    timeout_d = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + WCNT_ONE;
                end
            end
            S_TIMEOUT: begin
                state_d = S_TIMEOUT;
            end
            default: begin
                state_d = S_RUN;
                wcnt_d  = '0;
            end
        endcase
    end

    assign redirect_taken = !rst_i && !frozen && EX_redirect_i;
    assign stall_evt      = !rst_i && !pc_en_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= S_RUN;
            wcnt_q        <= '0;
            mem_timeout_o <= 1'b0;
            stall_cnt_o   <= '0;
            flush_cnt_o   <= '0;
        end else begin
            state_q       <= state_d;
            wcnt_q        <= wcnt_d;
            mem_timeout_o <= timeout_d;
            if (stall_evt && (stall_cnt_o != '1)) begin
                stall_cnt_o <= stall_cnt_o + 1'b1;
            end
            if (redirect_taken && (flush_cnt_o != '1)) begin
                flush_cnt_o <= flush_cnt_o + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed plus randomized bench for hazard_ctrl; two instances (default and
// CNT_W=4/TIMEOUT=4) share stimulus and are checked against a cycle-level model.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1, rs2, rd;
    logic       rs1_used, rs2_used, rd_wren, memrd, redirect, req, ack;

    logic        pc_en_a, ifid_en_a, ifid_fl_a, idex_en_a, idex_fl_a, exmem_en_a, bub_a, tmo_a;
    logic        pc_en_b, ifid_en_b, ifid_fl_b, idex_en_b, idex_fl_b, exmem_en_b, bub_b, tmo_b;
    logic [31:0] stall_a, flush_a;
    logic [3:0]  stall_b, flush_b;

    int vectors     = 0;
    int miscompares = 0;
    bit started     = 0;

    // Model state per instance: 0 = CNT_W 32 / TIMEOUT 255, 1 = CNT_W 4 / TIMEOUT 4.
    int      tmo_lim[2] = '{255, 4};
    longint  cnt_cap[2] = '{64'hFFFF_FFFF, 64'd15};
    int      wait_len[2];
    bit      timed_out[2];
    longint  m_stall[2];
    longint  m_flush[2];

    always #5 clk = ~clk;

    hazard_ctrl dut_a (
        .clk_i(clk), .rst_i(rst),
        .IFID_rs1_i(rs1), .IFID_rs2_i(rs2),
        .IFID_rs1_used_i(rs1_used), .IFID_rs2_used_i(rs2_used),
        .IDEX_rd_i(rd), .IDEX_rd_wren_i(rd_wren), .IDEX_memrd_i(memrd),
        .EX_redirect_i(redirect), .dmem_req_i(req), .dmem_ack_i(ack),
        .pc_en_o(pc_en_a), .IFID_en_o(ifid_en_a), .IFID_flush_o(ifid_fl_a),
        .IDEX_en_o(idex_en_a), .IDEX_flush_o(idex_fl_a), .EXMEM_en_o(exmem_en_a),
        .MEMWB_bubble_o(bub_a), .mem_timeout_o(tmo_a),
        .stall_cnt_o(stall_a), .flush_cnt_o(flush_a)
    );

    hazard_ctrl #(.CNT_W(4), .TIMEOUT(4)) dut_b (
        .clk_i(clk), .rst_i(rst),
        .IFID_rs1_i(rs1), .IFID_rs2_i(rs2),
        .IFID_rs1_used_i(rs1_used), .IFID_rs2_used_i(rs2_used),
        .IDEX_rd_i(rd), .IDEX_rd_wren_i(rd_wren), .IDEX_memrd_i(memrd),
        .EX_redirect_i(redirect), .dmem_req_i(req), .dmem_ack_i(ack),
        .pc_en_o(pc_en_b), .IFID_en_o(ifid_en_b), .IFID_flush_o(ifid_fl_b),
        .IDEX_en_o(idex_en_b), .IDEX_flush_o(idex_fl_b), .EXMEM_en_o(exmem_en_b),
        .MEMWB_bubble_o(bub_b), .mem_timeout_o(tmo_b),
        .stall_cnt_o(stall_b), .flush_cnt_o(flush_b)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit m_frozen(input int i);
        return timed_out[i] || (!ack && (req || wait_len[i] > 0));
    endfunction

    // {pc_en, IFID_en, IFID_flush, IDEX_en, IDEX_flush, EXMEM_en, MEMWB_bubble}
    function automatic logic [6:0] m_ctrl(input int i);
        bit lu;
        lu = memrd && rd_wren && rd != 0
             && ((rs1_used && rs1 == rd) || (rs2_used && rs2 == rd));
        if (rst)               return 7'b0010101;
        else if (m_frozen(i))  return 7'b0000001;
        else if (redirect)     return 7'b1111110;
        else if (lu)           return 7'b0001110;
        else                   return 7'b1101010;
    endfunction

    task automatic tick();
        logic [6:0] got [2];
        logic [6:0] exp;
        #1;
        got[0] = {pc_en_a, ifid_en_a, ifid_fl_a, idex_en_a, idex_fl_a, exmem_en_a, bub_a};
        got[1] = {pc_en_b, ifid_en_b, ifid_fl_b, idex_en_b, idex_fl_b, exmem_en_b, bub_b};
        for (int i = 0; i < 2; i++) begin
            exp = m_ctrl(i);
            chk($sformatf("ctrl[%0d]", i), {57'd0, got[i]}, {57'd0, exp});
            if (started) begin
                chk($sformatf("stall_cnt[%0d]", i), i == 0 ? {32'd0, stall_a} : {60'd0, stall_b}, m_stall[i]);
                chk($sformatf("flush_cnt[%0d]", i), i == 0 ? {32'd0, flush_a} : {60'd0, flush_b}, m_flush[i]);
                chk($sformatf("mem_timeout[%0d]", i), {63'd0, i == 0 ? tmo_a : tmo_b}, {63'd0, timed_out[i]});
            end
            if (rst) begin
                wait_len[i] = 0; timed_out[i] = 0; m_stall[i] = 0; m_flush[i] = 0;
            end else begin
                if (exp[6] == 1'b0 && m_stall[i] < cnt_cap[i]) m_stall[i]++;
                if (!m_frozen(i) && redirect && m_flush[i] < cnt_cap[i]) m_flush[i]++;
                if (!timed_out[i]) begin
                    if (m_frozen(i)) begin
                        wait_len[i]++;
                        if (wait_len[i] > tmo_lim[i]) timed_out[i] = 1;
                    end else begin
                        wait_len[i] = 0;
                    end
                end
            end
        end
        if (rst) started = 1;
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 0; rs1 = 0; rs2 = 0; rd = 0; rs1_used = 0; rs2_used = 0;
        rd_wren = 0; memrd = 0; redirect = 0; req = 0; ack = 0;
    endtask

    task automatic do_reset();
        idle(); rst = 1; tick(); tick(); rst = 0;
    endtask

    initial begin
        idle();
        @(negedge clk);

        // Reset, then normal flow
        do_reset();
        tick();
        chk("post_reset_pc_en", {63'd0, pc_en_a}, 64'd1);

        // Load-use stall, then the rd=0 case that must not stall
        memrd = 1; rd_wren = 1; rd = 5; rs1 = 5; rs1_used = 1; tick();
        idle(); tick();
        chk("lu_stall_cnt", {32'd0, stall_a}, 64'd1);
        memrd = 1; rd_wren = 1; rd = 0; rs1 = 0; rs1_used = 1; tick();
        idle(); tick();
        chk("lu_rd0_stall_cnt", {32'd0, stall_a}, 64'd1);

        // Redirect beats load-use
        memrd = 1; rd_wren = 1; rd = 7; rs2 = 7; rs2_used = 1; redirect = 1; tick();
        idle(); tick();
        chk("redir_flush_cnt", {32'd0, flush_a}, 64'd1);
        chk("redir_stall_cnt", {32'd0, stall_a}, 64'd1);

        // Three frozen cycles with redirect held, then ack
        do_reset();
        req = 1; ack = 0; redirect = 1;
        repeat (3) tick();
        ack = 1; tick();
        idle(); tick();
        chk("memwait_stall_cnt", {32'd0, stall_a}, 64'd3);
        chk("memwait_flush_cnt", {32'd0, flush_a}, 64'd1);

        // Watchdog on the TIMEOUT=4 instance, then saturation in the TIMEOUT state
        do_reset();
        req = 1; ack = 0;
        repeat (4) tick();
        chk("wdog_before", {63'd0, tmo_b}, 64'd0);
        tick();
        chk("wdog_fired", {63'd0, tmo_b}, 64'd1);
        ack = 1; repeat (3) tick();
        chk("wdog_ack_ignored_pc_en", {63'd0, pc_en_b}, 64'd0);
        ack = 0; repeat (20) tick();
        chk("sat_stall_cnt", {60'd0, stall_b}, 64'd15);
        chk("wdog_sticky", {63'd0, tmo_b}, 64'd1);
        do_reset();
        tick();
        chk("wdog_cleared", {63'd0, tmo_b}, 64'd0);

        // Default instance watchdog at TIMEOUT=255
        req = 1; ack = 0;
        repeat (258) tick();
        chk("wdog_a_fired", {63'd0, tmo_a}, 64'd1);
        do_reset();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst      = ($urandom_range(0, 63) == 0);
            rs1      = 5'($urandom_range(0, 3));
            rs2      = 5'($urandom_range(0, 3));
            rd       = 5'($urandom_range(0, 3));
            rs1_used = 1'($urandom);
            rs2_used = 1'($urandom);
            rd_wren  = ($urandom_range(0, 3) != 0);
            memrd    = 1'($urandom);
            redirect = ($urandom_range(0, 5) == 0);
            req      = ($urandom_range(0, 9) < 3);
            ack      = 1'($urandom);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage core. It generates the enables and flushes for PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It decides three things:
- load-use stalls, for hazards the EX forwarding unit cannot cover;
- control-redirect flushes;
- whole-pipeline freezes while a data-memory access awaits acknowledge, with a watchdog timeout.

It sits in ID beside the ID/EX register, so it decides what reaches the forwarding unit one cycle later. It also keeps saturating stall and flush performance counters.

## Interface
Parameters:
- CNT_W, 32: width of performance counters.
- TIMEOUT, 255: maximum MEM_WAIT cycles before the watchdog fires; must be ≥1.

Ports:
- clk_i  in  1  single clock, rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- IFID_rs1_i  in  5  rs1 of instruction in ID.
- IFID_rs2_i  in  5  rs2 of instruction in ID.
- IFID_rs1_used_i  in  1  ID instruction reads rs1.
- IFID_rs2_used_i  in  1  ID instruction reads rs2.
- IDEX_rd_i  in  5  rd of instruction in EX.
- IDEX_rd_wren_i  in  1  EX instruction writes rd.
- IDEX_memrd_i  in  1  EX instruction is a load.
- EX_redirect_i  in  1  EX resolved a taken branch or jump mispredict.
- dmem_req_i  in  1  MEM stage issuing a data-memory access.
- dmem_ack_i  in  1  data memory completes the access this cycle.
- pc_en_o  out  1  PC update enable.
- IFID_en_o  out  1  IF/ID register enable.
- IFID_flush_o  out  1  IF/ID register loads a bubble.
- IDEX_en_o  out  1  ID/EX register enable.
- IDEX_flush_o  out  1  ID/EX register loads a bubble.
- EXMEM_en_o  out  1  EX/MEM register enable.
- MEMWB_bubble_o  out  1  MEM/WB register loads a bubble.
- mem_timeout_o  out  1  sticky watchdog error.
- stall_cnt_o  out  CNT_W  cycles with pc_en_o=0, excluding reset.
- flush_cnt_o  out  CNT_W  accepted redirects.

## Operation
FSM states: RUN, MEM_WAIT, TIMEOUT. A wait counter wcnt has width clog2(TIMEOUT+1).

Reset (rst_i=1 at a clock edge):
- State goes to RUN; wcnt, counters and mem_timeout_o clear.
- Outputs are combinational. Whenever rst_i=1 they are: all enables 0, IFID_flush_o=1, IDEX_flush_o=1, MEMWB_bubble_o=1.
- Reset mid-MEM_WAIT or in TIMEOUT returns to RUN on that edge.

Freeze condition:
- RUN: freeze when dmem_req_i & !dmem_ack_i.
- MEM_WAIT: freeze while !dmem_ack_i.
- TIMEOUT: always frozen.

While frozen:
- pc_en_o, IFID_en_o, IDEX_en_o and EXMEM_en_o are 0.
- MEMWB_bubble_o=1; both flushes are 0.

Load-use hazard (lu):
- lu = IDEX_memrd_i & IDEX_rd_wren_i & (IDEX_rd_i≠0) & ((IFID_rs1_used_i & rs1==rd) | (IFID_rs2_used_i & rs2==rd)).

Output priority, highest first:
1. Freeze.
2. EX_redirect_i: pc_en_o=1, IFID_en_o=1, IFID_flush_o=1, IDEX_en_o=1, IDEX_flush_o=1. Any lu is ignored, since the ID instruction is wrong-path.
3. lu: pc_en_o=0, IFID_en_o=0, IDEX_en_o=1, IDEX_flush_o=1, IFID_flush_o=0.
4. Otherwise: all enables 1, flushes 0, bubble 0.

A redirect coinciding with a freeze is not accepted. EX is held, so the redirect re-presents after the freeze ends.

Transitions:
- RUN → MEM_WAIT on freeze; wcnt←1.
- MEM_WAIT → RUN on dmem_ack_i. The ack cycle is not frozen and follows priorities 2–4.
- MEM_WAIT with !dmem_ack_i: if wcnt==TIMEOUT, go to TIMEOUT and set mem_timeout_o; otherwise wcnt←wcnt+1.
- TIMEOUT is held until reset; dmem_ack_i is ignored there.

Counters:
- stall_cnt_o increments each non-reset cycle with pc_en_o=0.
- flush_cnt_o increments each cycle priority 2 is applied.
- Both saturate at 2^CNT_W−1.

## Timing
- All control outputs are combinational from state and same-cycle inputs; zero-cycle latency.
- State, wcnt, counters and mem_timeout_o update on the rising edge.
- A counter reflects a cycle's event after that cycle's edge.
- A load-use stall lasts exactly 1 cycle: the bubble removes the load condition from ID/EX.
- A single-cycle access with req and ack in the same cycle never freezes.
- With TIMEOUT=T and no ack, mem_timeout_o rises after the edge ending the T+1th frozen cycle.
- mem_timeout_o is 0 after reset and remains 1 until rst_i.

## Test plan
- Reset: rst_i=1 for 2 cycles → enables 0, both flushes 1, counters 0, state RUN; the first cycle after reset shows all enables 1.
- Load-use: memrd=1, rd_wren=1, rd=5, rs1=5, rs1_used=1 for one cycle → pc_en=0, IFID_en=0, IDEX_flush=1; stall_cnt=1. Repeat with rd=0 → no stall.
- Redirect beats load-use: redirect=1 together with an lu condition → both flushes 1, pc_en=1; flush_cnt=1, stall_cnt unchanged.
- Memory wait: req=1, ack=0 for 3 cycles, then ack=1 → 3 frozen cycles with MEMWB_bubble=1 and enables resuming in the ack cycle; stall_cnt=3. Redirect held throughout → flush_cnt increments only in the ack cycle.
- Watchdog: TIMEOUT=4, req=1, ack never → mem_timeout_o=1 after the 5th frozen cycle and stays set. A later ack keeps the freeze; rst_i clears everything.
- Saturation: CNT_W=4 with continuous freeze for 20 cycles → stall_cnt_o holds 15.
